lc3b_mem_if: RTL



---
 rtl/lc3b_pkg.sv | 26 ++
 rtl/lc3b_byte_lane.sv | 44 ++++
 rtl/lc3b_mem_if.sv | 133 +++++++++++++
 3 files changed

// File: rtl/lc3b_pkg.sv
// Shared LC-3b definitions: memory-interface states,
// lane-geometry helpers and byte sign extension.
package lc3b_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    // Widest datapath any derivative is expected to use.
    localparam int SEXT_W = 256;

    function automatic int lanes_of(input int dw);
        return dw / 8;
    endfunction

    function automatic int lb_of(input int dw);
        return $clog2(dw / 8);
    endfunction

    function automatic logic [SEXT_W-1:0] sext8(input logic [7:0] b);
        return {{(SEXT_W-8){b[7]}}, b};
    endfunction

endpackage

// File: rtl/lc3b_byte_lane.sv
// Byte-lane steering: byte enables, store-data replication
// and load-data lane select with sign extension.
module lc3b_byte_lane
    import lc3b_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LANES  = DATA_W / 8,
    parameter int LB     = $clog2(LANES)
) (
    input  logic [LB-1:0]     lane,
    input  logic              is_byte,
    input  logic              write,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic [LANES-1:0]  be,
    output logic [DATA_W-1:0] wdata_out,
    output logic [DATA_W-1:0] rdata_out
);

    logic [DATA_W-1:0] shifted;
    logic [SEXT_W-1:0] ext;

    assign shifted = rdata >> {lane, 3'b000};
    assign ext     = sext8(shifted[7:0]);

    // Steer lanes for the access size; stores return no data.
    always_comb begin
        be        = '1;
        wdata_out = wdata;
        rdata_out = rdata;
        if (is_byte) begin
            be = LANES'(1) << lane;
        end
        if (write && is_byte) begin
            wdata_out = {LANES{wdata[7:0]}};
        end
        if (write) begin
            rdata_out = '0;
        end else if (is_byte) begin
            rdata_out = ext[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/lc3b_mem_if.sv
// LC-3b memory interface: valid/ready request channel to an
// ack-based memory port with lane steering and wait timeout.
module lc3b_mem_if
    import lc3b_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15,
    parameter int LANES   = lanes_of(DATA_W),
    parameter int LB      = lb_of(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic              req_byte,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [LANES-1:0]  mem_be,
    output logic [ADDR_W-LB-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nxt;
    logic              q_write;
    logic              q_byte;
    logic [ADDR_W-1:0] q_addr;
    logic [DATA_W-1:0] q_wdata;
    logic [LANES-1:0]  lane_be;
    logic [DATA_W-1:0] lane_wdata;
    logic [DATA_W-1:0] lane_rdata;
    logic              misaligned;

    lc3b_byte_lane #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .LB     (LB)
    ) u_lane (
        .lane      (q_addr[LB-1:0]),
        .is_byte   (q_byte),
        .write     (q_write),
        .wdata     (q_wdata),
        .rdata     (mem_rdata),
        .be        (lane_be),
        .wdata_out (lane_wdata),
        .rdata_out (lane_rdata)
    );

    assign misaligned = !req_byte && (req_addr[LB-1:0] != '0);
    assign cnt_nxt    = (cnt == CW'(TIMEOUT)) ? cnt : cnt + 1'b1;
    assign req_ready  = (state == IDLE);

    // Memory port is driven from the latched request only while
    // mem_en is up, so an asynchronous reset clears it at once.
    assign mem_we    = mem_en & q_write;
    assign mem_be    = mem_en ? lane_be : '0;
    assign mem_addr  = mem_en ? q_addr[ADDR_W-1:LB] : '0;
    assign mem_wdata = mem_en ? lane_wdata : '0;

    // Request FSM: accept, wait for ack or timeout, respond.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            q_write   <= 1'b0;
            q_byte    <= 1'b0;
            q_addr    <= '0;
            q_wdata   <= '0;
            mem_en    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        q_write <= req_write;
                        q_byte  <= req_byte;
                        q_addr  <= req_addr;
                        q_wdata <= req_wdata;
                        cnt     <= '0;
                        if (misaligned) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            state  <= BUSY;
                            mem_en <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt_nxt;
                    if (mem_ack) begin
                        state     <= RESP;
                        mem_en    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= lane_rdata;
                    end else if (cnt_nxt == CW'(TIMEOUT)) begin
                        state     <= RESP;
                        mem_en    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    mem_en <= 1'b0;
                end
            endcase
        end
    end

endmodule
